// File: rtl/gpr_wb_ctl.sv
// GPR writeback controller: arbitrates the single GPR write port between the
// ALU (wb0) and LSU (wb1) requesters, registers the chosen write, and keeps a
// 32-entry busy scoreboard with read-hazard checks.
module gpr_wb_ctl #(
    parameter bit SB_EN = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        iss_val,
    input  logic [4:0]  iss_adr,
    output logic        iss_rdy,
    input  logic        wb0_val,
    input  logic [4:0]  wb0_adr,
    input  logic [31:0] wb0_dat,
    output logic        wb0_rdy,
    input  logic        wb1_val,
    input  logic [4:0]  wb1_adr,
    input  logic [31:0] wb1_dat,
    output logic        wb1_rdy,
    output logic        gpr_wr_en,
    output logic [4:0]  gpr_wr_adr,
    output logic [31:0] gpr_wr_dat,
    input  logic [4:0]  chk_adr_0,
    input  logic [4:0]  chk_adr_1,
    input  logic [4:0]  chk_adr_2,
    output logic        chk_busy_0,
    output logic        chk_busy_1,
    output logic        chk_busy_2,
    output logic [31:0] busy_vec,
    output logic        sb_err
);

    logic [31:0] busy_q, busy_d;
    logic        rr_last_q, rr_last_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_adr_q, wr_adr_d;
    logic [31:0] wr_dat_q, wr_dat_d;
    logic        sb_err_q, sb_err_d;

    logic        xfer;
    logic [4:0]  xfer_adr;
    logic        xfer_bit_live;

    // Grant logic: a tie goes to the requester that did not win last time.
    // Grants are withheld while rst is high so no write follows reset.
    always_comb begin
        wb0_rdy = 1'b0;
        wb1_rdy = 1'b0;
        if (!rst) begin
            wb0_rdy = wb0_val & (~wb1_val | rr_last_q);
            wb1_rdy = wb1_val & (~wb0_val | ~rr_last_q);
        end
    end

    // Issue acceptance and hazard checks against registered scoreboard state.
    always_comb begin
        iss_rdy    = 1'b1;
        chk_busy_0 = 1'b0;
        chk_busy_1 = 1'b0;
        chk_busy_2 = 1'b0;
        if (SB_EN) begin
            iss_rdy    = ~busy_q[iss_adr];
            chk_busy_0 = busy_q[chk_adr_0];
            chk_busy_1 = busy_q[chk_adr_1];
            chk_busy_2 = busy_q[chk_adr_2];
        end
    end

    // Next-state: capture the granted write, update scoreboard and error flag.
    always_comb begin
        xfer      = (wb0_val & wb0_rdy) | (wb1_val & wb1_rdy);
        xfer_adr  = (wb0_val & wb0_rdy) ? wb0_adr : wb1_adr;
        rr_last_d = rr_last_q;
        wr_en_d   = xfer;
        wr_adr_d  = wr_adr_q;
        wr_dat_d  = wr_dat_q;
        busy_d    = busy_q;
        sb_err_d  = sb_err_q;

        if (wb0_val & wb0_rdy) begin
            rr_last_d = 1'b0;
            wr_adr_d  = wb0_adr;
            wr_dat_d  = wb0_dat;
        end else if (wb1_val & wb1_rdy) begin
            rr_last_d = 1'b1;
            wr_adr_d  = wb1_adr;
            wr_dat_d  = wb1_dat;
        end

        // A bit whose clear is already in flight counts as free, so a second
        // back-to-back write to the same register is flagged.
        xfer_bit_live = busy_q[xfer_adr] & ~(wr_en_q && (wr_adr_q == xfer_adr));

        if (SB_EN) begin
            if (wr_en_q) begin
                busy_d[wr_adr_q] = 1'b0;
            end
            if (iss_val && iss_rdy) begin
                busy_d[iss_adr] = 1'b1;
            end
            if (xfer && !xfer_bit_live) begin
                sb_err_d = 1'b1;
            end
        end else begin
            busy_d   = '0;
            sb_err_d = 1'b0;
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= '0;
            rr_last_q <= 1'b1;
            wr_en_q   <= 1'b0;
            wr_adr_q  <= '0;
            wr_dat_q  <= '0;
            sb_err_q  <= 1'b0;
        end else begin
            busy_q    <= busy_d;
            rr_last_q <= rr_last_d;
            wr_en_q   <= wr_en_d;
            wr_adr_q  <= wr_adr_d;
            wr_dat_q  <= wr_dat_d;
            sb_err_q  <= sb_err_d;
        end
    end

    assign gpr_wr_en  = wr_en_q;
    assign gpr_wr_adr = wr_adr_q;
    assign gpr_wr_dat = wr_dat_q;
    assign busy_vec   = busy_q;
    assign sb_err     = sb_err_q;

endmodule

// File: tb/tb_gpr_wb_ctl.sv
// Directed bench for gpr_wb_ctl; a second instance with SB_EN=0 shares inputs.
module tb_gpr_wb_ctl;

    logic        clk = 1'b0;
    logic        rst;
    logic        iss_val;
    logic [4:0]  iss_adr;
    logic        wb0_val, wb1_val;
    logic [4:0]  wb0_adr, wb1_adr;
    logic [31:0] wb0_dat, wb1_dat;
    logic [4:0]  chk_adr_0, chk_adr_1, chk_adr_2;

    logic        iss_rdy, wb0_rdy, wb1_rdy, gpr_wr_en;
    logic [4:0]  gpr_wr_adr;
    logic [31:0] gpr_wr_dat, busy_vec;
    logic        chk_busy_0, chk_busy_1, chk_busy_2, sb_err;

    logic        n_iss_rdy, n_wb0_rdy, n_wb1_rdy, n_gpr_wr_en;
    logic [4:0]  n_gpr_wr_adr;
    logic [31:0] n_gpr_wr_dat, n_busy_vec;
    logic        n_chk_busy_0, n_chk_busy_1, n_chk_busy_2, n_sb_err;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    gpr_wb_ctl #(.SB_EN(1'b1)) dut (
        .clk(clk), .rst(rst),
        .iss_val(iss_val), .iss_adr(iss_adr), .iss_rdy(iss_rdy),
        .wb0_val(wb0_val), .wb0_adr(wb0_adr), .wb0_dat(wb0_dat), .wb0_rdy(wb0_rdy),
        .wb1_val(wb1_val), .wb1_adr(wb1_adr), .wb1_dat(wb1_dat), .wb1_rdy(wb1_rdy),
        .gpr_wr_en(gpr_wr_en), .gpr_wr_adr(gpr_wr_adr), .gpr_wr_dat(gpr_wr_dat),
        .chk_adr_0(chk_adr_0), .chk_adr_1(chk_adr_1), .chk_adr_2(chk_adr_2),
        .chk_busy_0(chk_busy_0), .chk_busy_1(chk_busy_1), .chk_busy_2(chk_busy_2),
        .busy_vec(busy_vec), .sb_err(sb_err)
    );

    gpr_wb_ctl #(.SB_EN(1'b0)) dut_nosb (
        .clk(clk), .rst(rst),
        .iss_val(iss_val), .iss_adr(iss_adr), .iss_rdy(n_iss_rdy),
        .wb0_val(wb0_val), .wb0_adr(wb0_adr), .wb0_dat(wb0_dat), .wb0_rdy(n_wb0_rdy),
        .wb1_val(wb1_val), .wb1_adr(wb1_adr), .wb1_dat(wb1_dat), .wb1_rdy(n_wb1_rdy),
        .gpr_wr_en(n_gpr_wr_en), .gpr_wr_adr(n_gpr_wr_adr), .gpr_wr_dat(n_gpr_wr_dat),
        .chk_adr_0(chk_adr_0), .chk_adr_1(chk_adr_1), .chk_adr_2(chk_adr_2),
        .chk_busy_0(n_chk_busy_0), .chk_busy_1(n_chk_busy_1), .chk_busy_2(n_chk_busy_2),
        .busy_vec(n_busy_vec), .sb_err(n_sb_err)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sample point: the falling edge, away from the active edge.
    task automatic smp();
        @(negedge clk);
    endtask

    initial begin
        int k0, k1, writes;
        logic [4:0] prev_adr;
        logic       expect_wr;

        rst = 1'b1; iss_val = 1'b0; iss_adr = '0;
        wb0_val = 1'b1; wb0_adr = 5'd1; wb0_dat = 32'h1;
        wb1_val = 1'b0; wb1_adr = '0; wb1_dat = '0;
        chk_adr_0 = 5'd5; chk_adr_1 = 5'd0; chk_adr_2 = 5'd31;

        // Reset held with a pending wb0 request.
        tick(); smp();
        chk("rst_wb0_rdy", {31'b0, wb0_rdy}, 32'd0);
        tick();
        rst = 1'b0; wb0_val = 1'b0;
        smp();
        chk("rst_wr_en", {31'b0, gpr_wr_en}, 32'd0);
        chk("rst_busy", busy_vec, 32'd0);
        chk("rst_sb_err", {31'b0, sb_err}, 32'd0);
        chk("rst_adr", {27'b0, gpr_wr_adr}, 32'd0);
        chk("rst_dat", gpr_wr_dat, 32'd0);

        // Issue r5, then wb0 writes r5.
        tick();
        iss_val = 1'b1; iss_adr = 5'd5;
        smp();
        chk("r5_iss_rdy", {31'b0, iss_rdy}, 32'd1);
        tick();
        iss_val = 1'b0;
        wb0_val = 1'b1; wb0_adr = 5'd5; wb0_dat = 32'hDEADBEEF;
        smp();
        chk("r5_wb0_rdy", {31'b0, wb0_rdy}, 32'd1);
        chk("r5_busy_pre", {31'b0, chk_busy_0}, 32'd1);
        chk("r5_busy_vec", busy_vec, 32'h20);
        tick();
        wb0_val = 1'b0;
        smp();
        chk("r5_wr_en", {31'b0, gpr_wr_en}, 32'd1);
        chk("r5_wr_adr", {27'b0, gpr_wr_adr}, 32'd5);
        chk("r5_wr_dat", gpr_wr_dat, 32'hDEADBEEF);
        chk("r5_busy_wr", {31'b0, chk_busy_0}, 32'd1);
        tick(); smp();
        chk("r5_wr_en_off", {31'b0, gpr_wr_en}, 32'd0);
        chk("r5_wr_dat_hold", gpr_wr_dat, 32'hDEADBEEF);
        chk("r5_busy_post", {31'b0, chk_busy_0}, 32'd0);
        chk("r5_sb_err", {31'b0, sb_err}, 32'd0);

        // Fresh reset, issue r3 and r7, then tie between wb0(r3) and wb1(r7).
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        iss_val = 1'b1; iss_adr = 5'd3;
        tick(); iss_adr = 5'd7;
        tick(); iss_val = 1'b0;
        wb0_val = 1'b1; wb0_adr = 5'd3; wb0_dat = 32'h33;
        wb1_val = 1'b1; wb1_adr = 5'd7; wb1_dat = 32'h77;
        smp();
        chk("tie_c1_wb0", {31'b0, wb0_rdy}, 32'd1);
        chk("tie_c1_wb1", {31'b0, wb1_rdy}, 32'd0);
        chk("tie_busy0", busy_vec, 32'h88);
        tick(); wb0_val = 1'b0;
        smp();
        chk("tie_c2_wb1", {31'b0, wb1_rdy}, 32'd1);
        chk("tie_w1_adr", {27'b0, gpr_wr_adr}, 32'd3);
        chk("tie_w1_dat", gpr_wr_dat, 32'h33);
        tick(); wb1_val = 1'b0;
        smp();
        chk("tie_w2_en", {31'b0, gpr_wr_en}, 32'd1);
        chk("tie_w2_adr", {27'b0, gpr_wr_adr}, 32'd7);
        chk("tie_w2_dat", gpr_wr_dat, 32'h77);
        chk("tie_busy1", busy_vec, 32'h80);
        tick(); smp();
        chk("tie_busy2", busy_vec, 32'h0);
        chk("tie_sb_err", {31'b0, sb_err}, 32'd0);

        // Continuous contention: wb0 writes r10..r15, wb1 writes r20..r25.
        tick();
        for (int i = 0; i < 6; i++) begin
            iss_val = 1'b1; iss_adr = 5'(10 + i); tick();
            iss_adr = 5'(20 + i); tick();
        end
        iss_val = 1'b0;
        k0 = 0; k1 = 0; writes = 0; prev_adr = '0;
        for (int i = 0; i < 12; i++) begin
            wb0_val = (k0 < 6); wb0_adr = 5'(10 + k0); wb0_dat = 32'hA000_0000 + k0;
            wb1_val = (k1 < 6); wb1_adr = 5'(20 + k1); wb1_dat = 32'hB000_0000 + k1;
            smp();
            expect_wr = (i % 2 == 0);
            chk("cont_wb0_rdy", {31'b0, wb0_rdy}, {31'b0, expect_wr});
            chk("cont_wb1_rdy", {31'b0, wb1_rdy}, {31'b0, ~expect_wr});
            if (i > 0) begin
                chk("cont_wr_adr", {27'b0, gpr_wr_adr}, {27'b0, prev_adr});
                if (gpr_wr_en) writes++;
            end
            if (expect_wr) begin prev_adr = 5'(10 + k0); k0++; end
            else begin prev_adr = 5'(20 + k1); k1++; end
            tick();
        end
        wb0_val = 1'b0; wb1_val = 1'b0;
        smp();
        chk("cont_last_adr", {27'b0, gpr_wr_adr}, {27'b0, prev_adr});
        if (gpr_wr_en) writes++;
        chk("cont_writes", writes, 32'd12);
        tick(); smp();
        chk("cont_busy", busy_vec, 32'h0);
        chk("cont_sb_err", {31'b0, sb_err}, 32'd0);

        // WAW stall on r9.
        tick();
        iss_val = 1'b1; iss_adr = 5'd9;
        smp();
        chk("waw_first", {31'b0, iss_rdy}, 32'd1);
        tick();
        wb1_val = 1'b1; wb1_adr = 5'd9; wb1_dat = 32'h99;
        smp();
        chk("waw_stall0", {31'b0, iss_rdy}, 32'd0);
        chk("waw_wb1_rdy", {31'b0, wb1_rdy}, 32'd1);
        tick(); wb1_val = 1'b0;
        smp();
        chk("waw_wr_en", {31'b0, gpr_wr_en}, 32'd1);
        chk("waw_stall1", {31'b0, iss_rdy}, 32'd0);
        tick(); smp();
        chk("waw_release", {31'b0, iss_rdy}, 32'd1);
        tick(); iss_val = 1'b0;
        smp();
        chk("waw_reset_bit", busy_vec, 32'h200);
        wb0_val = 1'b1; wb0_adr = 5'd9; wb0_dat = 32'h9;
        tick(); wb0_val = 1'b0;
        tick(); smp();
        chk("waw_clean", busy_vec, 32'h0);
        chk("waw_sb_err", {31'b0, sb_err}, 32'd0);

        // Same register granted twice back to back: second flags an error.
        tick();
        iss_val = 1'b1; iss_adr = 5'd14;
        tick(); iss_val = 1'b0;
        wb0_val = 1'b1; wb0_adr = 5'd14; wb0_dat = 32'h14;
        wb1_val = 1'b1; wb1_adr = 5'd14; wb1_dat = 32'h41;
        tick(); wb0_val = 1'b0;
        smp();
        chk("dup_c2_wb1", {31'b0, wb1_rdy}, 32'd1);
        chk("dup_c2_err", {31'b0, sb_err}, 32'd0);
        tick(); wb1_val = 1'b0;
        smp();
        chk("dup_err", {31'b0, sb_err}, 32'd1);
        chk("dup_dat", gpr_wr_dat, 32'h41);

        // wb1 writes r12 with its bit clear.
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        wb1_val = 1'b1; wb1_adr = 5'd12; wb1_dat = 32'hC;
        smp();
        chk("err_wb1_rdy", {31'b0, wb1_rdy}, 32'd1);
        chk("err_pre", {31'b0, sb_err}, 32'd0);
        tick(); wb1_val = 1'b0;
        smp();
        chk("err_wr_en", {31'b0, gpr_wr_en}, 32'd1);
        chk("err_wr_adr", {27'b0, gpr_wr_adr}, 32'd12);
        chk("err_set", {31'b0, sb_err}, 32'd1);
        chk("nosb_err", {31'b0, n_sb_err}, 32'd0);
        chk("nosb_wr_en", {31'b0, n_gpr_wr_en}, 32'd1);
        iss_val = 1'b1; iss_adr = 5'd4;
        tick(); tick();
        smp();
        chk("err_sticky", {31'b0, sb_err}, 32'd1);
        chk("nosb_iss_rdy", {31'b0, n_iss_rdy}, 32'd1);
        chk("sb_iss_rdy_busy", {31'b0, iss_rdy}, 32'd0);
        chk("nosb_busy", n_busy_vec, 32'h0);
        chk_adr_1 = 5'd4;
        #1;
        chk("sb_chk_busy_1", {31'b0, chk_busy_1}, 32'd1);
        chk("nosb_chk_busy_1", {31'b0, n_chk_busy_1}, 32'd0);
        iss_val = 1'b0;
        tick(); rst = 1'b1;
        tick(); rst = 1'b0;
        smp();
        chk("err_cleared", {31'b0, sb_err}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
